axis_arbiter_2: RTL and testbench
=================================

Name: axis_arbiter_2

Overview:
Packet-aware round-robin arbiter that merges two AXI-Stream sources onto one output stream. It is the counterpart of the 2-way stream splitter: it lets two producers share a single downstream consumer. Once it grants a packet it holds that grant until the beat flagged last, so packets are never interleaved. The output is registered, giving 1-cycle latency at full throughput of 1 beat/cycle.

Parameters:
DATA_WIDTH, 16, width of the data bus on all streams.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
input_0_valid  in  1  source 0 beat valid
input_0_ready  out  1  source 0 beat accepted when high together with valid
input_0_data  in  DATA_WIDTH  source 0 payload
input_0_last  in  1  source 0 end-of-packet flag
input_1_valid  in  1  source 1 beat valid
input_1_ready  out  1  source 1 ready
input_1_data  in  DATA_WIDTH  source 1 payload
input_1_last  in  1  source 1 end-of-packet flag
output_valid  out  1  merged stream valid (registered)
output_ready  in  1  downstream ready
output_data  out  DATA_WIDTH  merged payload (registered)
output_last  out  1  merged end-of-packet (registered)
output_source  out  1  id of the source that produced the current output beat (registered)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, priority=0, output_valid=0, output_data=0, output_last=0, output_source=0. Both input readies are 0 while rst=0. Reset asserted mid-packet discards the packet; no partial beat survives.
- slot_free = !output_valid || output_ready. The output register loads on any cycle where slot_free=1 and an input transfer occurs. If slot_free=1 and no transfer occurs, output_valid is cleared.
- Grant selection (combinational):
  - LOCK_0 -> sel=0; LOCK_1 -> sel=1.
  - IDLE: if exactly one input is valid, sel = that input. If both are valid, sel = priority. If neither is valid, no grant.
- input_x_ready = granted(x) && slot_free. The non-selected input always has ready=0. Ready never depends on the input's own valid, except through the IDLE grant.
- Transfer on input x: output_data<=data_x, output_last<=last_x, output_source<=x, output_valid<=1.
  - If last_x=1: next state IDLE, priority <= ~x.
  - If last_x=0: next state LOCK_x.
- States:
  - IDLE -> LOCK_x on a non-last transfer from x.
  - LOCK_x -> IDLE on a last transfer from x.
  - LOCK_x stays in LOCK_x otherwise, including when x drops valid mid-packet (bubbles allowed). The other source waits.
- Single-beat packet (last=1 on the first beat) is handled entirely in IDLE; the state never leaves IDLE and priority still toggles.
- Backpressure: output_valid=1 and output_ready=0 holds output_* stable. Both readies are 0 and state and priority are unchanged.
- Latency: input beat accepted in cycle N appears on output in cycle N+1. With output_ready held high, a new beat can be accepted every cycle, including back-to-back packets from alternating sources with no idle cycle.
- priority changes only on a last transfer, never on arbitration alone.

Decomposition:
- Package axis_arbiter_pkg: enum arb_state_t {IDLE, LOCK_0, LOCK_1}; typedef logic source_id_t; constants SRC_0=0, SRC_1=1.
- Sub-module axis_output_register (DATA_WIDTH+2 bits: data, last, source), containing the valid/slot_free logic. It is reusable for later N-way arbiters. The FSM, priority and grant logic stay in the top.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with both inputs valid -> both readies=0, output_valid=0, output_data=0. Release rst -> in the first cycle, input_0_ready=1 (priority=0).
2. Both sources offer 3-beat packets simultaneously (src0 data 0x0010..0x0012, src1 data 0x0020..0x0022), output_ready=1 -> output carries 0x0010,0x0011,0x0012 (last on 0x0012, source=0), then 0x0020..0x0022 (source=1) in 6 consecutive cycles, with no gap.
3. Lock hold: src0 sends beat 0x0001 (last=0), then drops valid for 3 cycles while src1 is valid -> input_1_ready stays 0. src0 then sends 0x0002 last=1 -> next cycle input_1_ready=1.
4. Backpressure: output_ready=0 for 4 cycles while holding beat 0x00AA -> output_data stays 0x00AA, output_valid=1, both readies=0. Releasing output_ready resumes with the next beat exactly once, with no loss or duplication.
5. Fairness: both sources continuously send 1-beat packets (last=1) -> output_source alternates 0,1,0,1 for 8 beats.
6. Async reset mid-packet: assert rst=0 between clock edges during LOCK_1 -> output_valid drops immediately. After release, state is IDLE and priority=0, so src0 is granted first.

Source files
------------

// File: rtl/axis_arbiter_pkg.sv
// axis_arbiter_pkg: shared FSM state, source id type and source constants
package axis_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, LOCK_0, LOCK_1} arb_state_t;
    typedef logic source_id_t;
    localparam source_id_t SRC_0 = 1'b0;
    localparam source_id_t SRC_1 = 1'b1;
endpackage

// File: rtl/axis_output_register.sv
// axis_output_register: registered stream output stage; loads when the slot is free
// and clears valid when the slot frees with nothing to load.
module axis_output_register #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_payload,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_payload,
    output logic             o_slot_free
);
    logic             r_valid;
    logic [WIDTH-1:0] r_payload;
    logic             w_slot_free;

    assign w_slot_free = !r_valid || i_ready;
    assign o_slot_free = w_slot_free;
    assign o_valid     = r_valid;
    assign o_payload   = r_payload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (w_slot_free) begin
            r_valid <= i_load;
            if (i_load)
                r_payload <= i_payload;
        end
    end
endmodule

// File: rtl/axis_arbiter_2.sv
// axis_arbiter_2: packet-aware round-robin merge of two AXI-Stream sources
// into one registered output stream.
module axis_arbiter_2
    import axis_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_0_valid,
    output logic                  input_0_ready,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    input  logic                  input_0_last,
    input  logic                  input_1_valid,
    output logic                  input_1_ready,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    input  logic                  input_1_last,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_last,
    output logic                  output_source
);
    arb_state_t  r_state, w_next_state;
    source_id_t  r_priority, w_next_priority;
    source_id_t  w_sel;
    logic        w_grant, w_slot_free, w_xfer, w_last;
    logic [DATA_WIDTH+1:0] w_in_payload, w_out_payload;

    // A lock pins the grant for the rest of the packet, even across bubbles.
    assign w_grant = rst && (r_state != IDLE || input_0_valid || input_1_valid);
    assign w_sel   = (r_state == LOCK_1) ? SRC_1 :
                     (r_state == LOCK_0) ? SRC_0 :
                     (input_0_valid && input_1_valid) ? r_priority :
                     input_1_valid ? SRC_1 : SRC_0;

    assign input_0_ready = w_grant && w_sel == SRC_0 && w_slot_free;
    assign input_1_ready = w_grant && w_sel == SRC_1 && w_slot_free;
    assign w_xfer        = (input_0_valid && input_0_ready) || (input_1_valid && input_1_ready);
    assign w_last        = (w_sel == SRC_1) ? input_1_last : input_0_last;
    assign w_in_payload  = {(w_sel == SRC_1) ? input_1_data : input_0_data, w_last, w_sel};

    always_comb begin
        w_next_state    = r_state;
        w_next_priority = r_priority;
        if (w_xfer) begin
            w_next_state    = w_last ? IDLE : (w_sel == SRC_1) ? LOCK_1 : LOCK_0;
            w_next_priority = w_last ? ~w_sel : r_priority;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_priority <= SRC_0;
        end else begin
            r_state    <= w_next_state;
            r_priority <= w_next_priority;
        end
    end

    axis_output_register #(.WIDTH(DATA_WIDTH + 2)) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_xfer),
        .i_payload  (w_in_payload),
        .i_ready    (output_ready),
        .o_valid    (output_valid),
        .o_payload  (w_out_payload),
        .o_slot_free(w_slot_free)
    );

    assign {output_data, output_last, output_source} = w_out_payload;
endmodule

// File: tb/tb_axis_arbiter_2.sv
// tb_axis_arbiter_2: directed and randomized checks of the 2-way arbiter against
// a per-cycle behavioural model driven from two source packet queues.
module tb_axis_arbiter_2;
    localparam int DW = 16;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic last; logic src; } out_t;

    logic          clk = 1'b0, rst = 1'b0, ordy = 1'b1;
    logic          v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          input_0_ready, input_1_ready, output_valid, output_last, output_source;
    logic [DW-1:0] output_data;

    beat_t q0[$], q1[$];
    out_t  out_log[$];
    int    log_cyc[$];
    int    n_tests = 0, n_fail = 0, cyc = 0;
    bit    en0 = 1, en1 = 1, a0, a1;

    bit            m_valid, m_last, m_src;
    logic [DW-1:0] m_data;
    int            m_owner, m_prio;

    always #5 clk = ~clk;

    axis_arbiter_2 #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .input_0_valid(v0), .input_0_ready(input_0_ready), .input_0_data(d0), .input_0_last(l0),
        .input_1_valid(v1), .input_1_ready(input_1_ready), .input_1_data(d1), .input_1_last(l1),
        .output_valid(output_valid), .output_ready(ordy), .output_data(output_data),
        .output_last(output_last), .output_source(output_source)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_last = 0; m_src = 0; m_data = '0; m_owner = -1; m_prio = 0;
    endtask

    // Whom the arbiter should be serving this cycle (-1 = nobody).
    function automatic int grant();
        if (!rst) return -1;
        if (m_owner >= 0) return m_owner;
        if (v0 && v1) return m_prio;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic drive();
        if (en0 && q0.size() > 0) begin v0 = 1; d0 = q0[0].data; l0 = q0[0].last; end
        else begin v0 = 0; d0 = '0; l0 = 0; end
        if (en1 && q1.size() > 0) begin v1 = 1; d1 = q1[0].data; l1 = q1[0].last; end
        else begin v1 = 0; d1 = '0; l1 = 0; end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic tick();
        int g;
        bit sf, r0, r1, x0, x1;
        drive();
        @(negedge clk);
        sf = !m_valid || ordy;
        g  = grant();
        r0 = (g == 0) && sf;
        r1 = (g == 1) && sf;
        check("rdy0", input_0_ready, r0);
        check("rdy1", input_1_ready, r1);
        check("ovalid", output_valid, m_valid);
        check("odata", output_data, m_data);
        check("olast", output_last, m_last);
        check("osrc", output_source, m_src);
        if (output_valid && ordy) begin
            out_log.push_back('{output_data, output_last, output_source});
            log_cyc.push_back(cyc);
        end
        x0 = r0 && v0; x1 = r1 && v1;
        a0 = x0; a1 = x1;
        @(posedge clk);
        cyc++;
        if (rst) begin
            if (sf) m_valid = x0 || x1;
            if (x0 || x1) begin
                m_data = x0 ? d0 : d1;
                m_last = x0 ? l0 : l1;
                m_src  = x1;
                if (m_last) begin m_owner = -1; m_prio = x1 ? 0 : 1; end
                else m_owner = x1 ? 1 : 0;
            end
            if (x0) void'(q0.pop_front());
            if (x1) void'(q1.pop_front());
        end
        #1;
    endtask

    task automatic push_pkt(input int src, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (src == 0) q0.push_back('{base + DW'(i), i == n - 1});
            else          q1.push_back('{base + DW'(i), i == n - 1});
        end
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        q0.delete(); q1.delete();
        en0 = 1; en1 = 1;
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        // Reset with both sources offering packets, then release
        push_pkt(0, 16'h0010, 3);
        push_pkt(1, 16'h0020, 3);
        tick();
        tick();
        settle();
        check("rst_rdy0", input_0_ready, 0);
        check("rst_rdy1", input_1_ready, 0);
        check("rst_ovalid", output_valid, 0);
        check("rst_odata", output_data, 0);
        rst = 1;
        settle();
        check("rel_rdy0", input_0_ready, 1);

        // Two simultaneous 3-beat packets, back to back with no gap
        out_log.delete(); log_cyc.delete();
        for (int i = 0; i < 20 && out_log.size() < 6; i++) tick();
        check("t2_count", out_log.size(), 6);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_data", out_log[i].data, (i < 3) ? 16'h0010 + i : 16'h0020 + i - 3);
                check("t2_src", out_log[i].src, i >= 3);
                check("t2_last", out_log[i].last, i == 2 || i == 5);
            end
            check("t2_nogap", log_cyc[5] - log_cyc[0], 5);
        end

        // Lock held across source-0 bubbles
        push_pkt(0, 16'h0001, 1);
        q0[$].last = 0;
        push_pkt(1, 16'h0030, 1);
        tick();
        en0 = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_hold_rdy1", input_1_ready, 0);
            tick();
        end
        push_pkt(0, 16'h0002, 1);
        en0 = 1;
        tick();
        settle();
        check("t3_rel_rdy1", input_1_ready, 1);
        for (int i = 0; i < 4; i++) tick();

        // Backpressure holds the output beat
        out_log.delete();
        push_pkt(0, 16'h00AA, 2);
        tick();
        ordy = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t4_data", output_data, 16'h00AA);
            check("t4_valid", output_valid, 1);
            check("t4_rdy0", input_0_ready, 0);
            check("t4_rdy1", input_1_ready, 0);
            tick();
        end
        ordy = 1;
        for (int i = 0; i < 4; i++) tick();
        check("t4_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t4_first", out_log[0].data, 16'h00AA);
            check("t4_second", out_log[1].data, 16'h00AB);
        end

        // Fairness with continuous single-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 16'h0050 + i, 1);
            push_pkt(1, 16'h0060 + i, 1);
        end
        out_log.delete();
        for (int i = 0; i < 30 && out_log.size() < 8; i++) tick();
        check("t5_count", out_log.size(), 8);
        foreach (out_log[i]) check("t5_alt", out_log[i].src, i % 2);

        // Asynchronous reset in the middle of a source-1 packet
        do_reset();
        push_pkt(1, 16'h0070, 3);
        tick();
        #2;
        rst = 0;
        model_reset();
        q0.delete(); q1.delete();
        #1;
        check("t6_ovalid", output_valid, 0);
        check("t6_rdy1", input_1_ready, 0);
        tick();
        rst = 1;
        push_pkt(0, 16'h0080, 1);
        push_pkt(1, 16'h0090, 1);
        settle();
        check("t6_rdy0", input_0_ready, 1);
        check("t6_rdy1b", input_1_ready, 0);
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic, bubbles and backpressure
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                push_pkt(0, DW'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 4));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                push_pkt(1, DW'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 4));
            if (!v0 || a0) en0 = $urandom_range(0, 3) != 0;
            if (!v1 || a1) en1 = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
